// File: rtl/alu_mdu.sv
// Execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops are combinational; MULT/DIV iterate on operand magnitudes and raise busy.
module alu_mdu #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUCt,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_MULT = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_MFHI = 5'b01010;
  localparam logic [4:0] OP_MFLO = 5'b01011;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_MTHI = 5'b01110;
  localparam logic [4:0] OP_MTLO = 5'b01111;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     cnt, cnt_nxt;

  // Operands latched at acceptance; prod doubles as {remainder, quotient} for DIV
  logic [DW-1:0]     prod;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  dividend;
  logic              neg_q, neg_r, div_zero, is_div;

  logic [SW-1:0]     sh;
  logic              slt;
  logic              can_accept, accept;
  logic              neg_a, neg_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [DW-1:0]     mul_res;
  logic [WIDTH-1:0]  fix_hi, fix_lo;

  // Combinational ALU
  assign sh  = in1[SW-1:0];
  assign slt = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

  always_comb begin
    out = '0;
    case (ALUCt)
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_SLT:  out = WIDTH'(slt);
      OP_NOR:  out = ~(in1 | in2);
      OP_XOR:  out = in1 ^ in2;
      OP_SLL:  out = in2 << sh;
      OP_SRL:  out = in2 >> sh;
      OP_SRA:  out = WIDTH'($signed(in2) >>> sh);
      OP_MFHI: out = hi;
      OP_MFLO: out = lo;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

  // A new op may be taken when idle or in the cycle the previous result lands
  assign can_accept = (state == S_IDLE) || (state == S_FIX);
  assign accept     = start && can_accept;

  assign neg_a = Sign && in1[WIDTH-1];
  assign neg_b = Sign && in2[WIDTH-1];
  assign mag_a = neg_a ? -in1 : in1;
  assign mag_b = neg_b ? -in2 : in2;

  // One shift-add multiply step and one restoring divide step
  assign mul_sum   = {1'b0, prod[DW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign div_shift = {prod[DW-1:WIDTH], prod[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};

  // Sign correction applied in FIX
  assign mul_res = neg_q ? -prod : prod;

  always_comb begin
    fix_hi = mul_res[DW-1:WIDTH];
    fix_lo = mul_res[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = dividend;
        fix_lo = '1;
      end else begin
        fix_hi = neg_r ? -prod[DW-1:WIDTH] : prod[DW-1:WIDTH];
        fix_lo = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_MUL: begin
        if (FAST_MUL || cnt == SW'(WIDTH - 1)) begin
          state_nxt = S_FIX;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DIV: begin
        if (cnt == SW'(WIDTH - 1)) begin
          state_nxt = S_FIX;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = state;
    endcase
    if (accept) begin
      if (ALUCt == OP_MULT) begin
        state_nxt = S_MUL;
      end else if (ALUCt == OP_DIV) begin
        state_nxt = S_DIV;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_FIX);
    end
  end

  // Datapath and HI/LO; an op accepted in FIX overrides the result being written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod     <= '0;
      mcand    <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_MUL: begin
          if (FAST_MUL) begin
            prod <= DW'(mcand) * DW'(prod[WIDTH-1:0]);
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) begin
            prod <= {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
          end else begin
            prod <= {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
      if (accept) begin
        case (ALUCt)
          OP_MULT: begin
            prod   <= {{WIDTH{1'b0}}, mag_b};
            mcand  <= mag_a;
            neg_q  <= neg_a ^ neg_b;
            is_div <= 1'b0;
          end
          OP_DIV: begin
            prod     <= {{WIDTH{1'b0}}, mag_a};
            mcand    <= mag_b;
            neg_q    <= neg_a ^ neg_b;
            neg_r    <= neg_a;
            div_zero <= (in2 == '0);
            dividend <= in1;
            is_div   <= 1'b1;
          end
          OP_MTHI: hi <= in1;
          OP_MTLO: lo <= in1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: arithmetic reference model checked every cycle, plus directed literal vectors.
module tb_alu_mdu;

  localparam int unsigned W     = 32;
  localparam int          NBUSY = W + 1;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_MULT = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_MFHI = 5'b01010;
  localparam logic [4:0] OP_MFLO = 5'b01011;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_MTHI = 5'b01110;
  localparam logic [4:0] OP_MTLO = 5'b01111;
  localparam logic [4:0] OP_SLL  = 5'b10000;
  localparam logic [4:0] OP_SRL  = 5'b11000;
  localparam logic [4:0] OP_SRA  = 5'b11001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   ALUCt = 5'b0;
  logic         Sign = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [W-1:0] out, hi, lo;
  logic         zero, busy, done;

  alu_mdu #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUCt(ALUCt), .Sign(Sign),
    .in1(in1), .in2(in2), .out(out), .zero(zero), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: busy-cycle countdown, pending result, architectural HI/LO
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic s, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return s ? {31'b0, ($signed(a) < $signed(b))} : {31'b0, (a < b)};
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      OP_SLL:  return b << a[4:0];
      OP_SRL:  return b >> a[4:0];
      OP_SRA:  return 32'($signed(b) >>> a[4:0]);
      OP_MFHI: return h;
      OP_MFLO: return l;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
      if (m_left > 0) m_left <= m_left - 1;
      if (start && m_left <= 1) begin
        case (ALUCt)
          OP_MULT: begin {p_hi, p_lo} <= ref_mul(Sign, in1, in2); m_left <= NBUSY; end
          OP_DIV:  begin {p_hi, p_lo} <= ref_div(Sign, in1, in2); m_left <= NBUSY; end
          OP_MTHI: m_hi <= in1;
          OP_MTLO: m_lo <= in1;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("out",  out,  ref_alu(ALUCt, Sign, in1, in2, m_hi, m_lo));
      check("zero", zero, ref_alu(ALUCt, Sign, in1, in2, m_hi, m_lo) == 32'h0);
      check("busy", busy, m_left > 0);
      check("done", done, m_left == 1);
      check("hi",   hi,   m_hi);
      check("lo",   lo,   m_lo);
    end
  end

  task automatic drive(input logic [4:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic st);
    @(posedge clk);
    #1;
    ALUCt = op; Sign = s; in1 = a; in2 = b; start = st;
  endtask

  task automatic alu_chk(input string nm, input logic [4:0] op, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
    drive(op, s, a, b, 1'b0);
    #1;
    check(nm, out, want);
    check({nm, "_zero"}, zero, want == 32'h0);
  endtask

  task automatic wait_busy(input bit to_done, output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) return;
      nb++;
      if (done) begin
        nd = nb;
        if (to_done) return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_busy: busy still high after 200 cycles, required low");
  endtask

  task automatic run_mdu(input string nm, input logic [4:0] op, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want_hi, input logic [31:0] want_lo);
    int nb, nd;
    drive(op, s, a, b, 1'b1);
    drive(OP_XOR, ~s, ~a, b ^ 32'h5A5A_5A5A, 1'b0);
    wait_busy(1'b0, nb, nd);
    check({nm, "_busy_cycles"}, 64'(nb), 64'(NBUSY));
    check({nm, "_done_cycle"}, 64'(nd), 64'(NBUSY));
    check({nm, "_hi"}, hi, want_hi);
    check({nm, "_lo"}, lo, want_lo);
  endtask

  initial begin
    int nb, nd;
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b1;

    alu_chk("add_ovf",  OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    alu_chk("sub_zero", OP_SUB, 1'b0, 32'h5, 32'h5, 32'h0);
    alu_chk("slt_s",    OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h1);
    alu_chk("slt_u",    OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    alu_chk("slt_min",  OP_SLT, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1);
    alu_chk("sra",      OP_SRA, 1'b0, 32'h4, 32'h8000_0000, 32'hF800_0000);
    alu_chk("sll31",    OP_SLL, 1'b0, 32'd31, 32'h3, 32'h8000_0000);
    alu_chk("srl",      OP_SRL, 1'b0, 32'h4, 32'h8000_0000, 32'h0800_0000);
    alu_chk("sll_shmask", OP_SLL, 1'b0, 32'h21, 32'h1, 32'h2);
    alu_chk("and",      OP_AND, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_chk("or",       OP_OR,  1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
    alu_chk("nor",      OP_NOR, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    alu_chk("xor",      OP_XOR, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu_chk("undef",    5'b00011, 1'b0, 32'h1, 32'h1, 32'h0);
    alu_chk("mult_comb", OP_MULT, 1'b0, 32'h3, 32'h3, 32'h0);

    drive(OP_MTHI, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
    drive(OP_MTLO, 1'b0, 32'h9ABC_DEF0, 32'h0, 1'b1);
    alu_chk("mfhi", OP_MFHI, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
    alu_chk("mflo", OP_MFLO, 1'b0, 32'h0, 32'h0, 32'h9ABC_DEF0);

    // Signed MULT with MFHI read while busy and operands changed after issue
    drive(OP_MULT, 1'b1, 32'hFFFF_FFFE, 32'h3, 1'b1);
    drive(OP_MFHI, 1'b0, 32'h7, 32'h9, 1'b0);
    #1;
    check("mfhi_busy", out, 32'h1234_5678);
    wait_busy(1'b0, nb, nd);
    check("mult_busy_cycles", 64'(nb), 64'd33);
    check("mult_done_cycle", 64'(nd), 64'd33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    run_mdu("multu_max", OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // Signed DIV with a second start issued while busy
    drive(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b1);
    drive(OP_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(OP_MULT, 1'b0, 32'h3, 32'h3, 1'b1);
    drive(OP_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_busy(1'b0, nb, nd);
    check("div_ign_busy_rest", 64'(nb), 64'd31);
    check("div_s_hi", hi, 32'hFFFF_FFFF);
    check("div_s_lo", lo, 32'hFFFF_FFFD);

    run_mdu("div_0",      OP_DIV,  1'b1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    run_mdu("div_ovf",    OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_mdu("mul_minmin", OP_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_mdu("divu_big",   OP_DIV,  1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    run_mdu("div_negdvs", OP_DIV,  1'b1, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);

    // Back-to-back: DIV accepted on the edge where the MULT's done is high
    drive(OP_MULT, 1'b1, 32'h7, 32'hFFFF_FFFA, 1'b1);
    drive(OP_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_busy(1'b1, nb, nd);
    check("b2b_done_cycle", 64'(nd), 64'd33);
    #1;
    ALUCt = OP_DIV; Sign = 1'b0; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; ALUCt = OP_AND;
    check("b2b_mul_hi", hi, 32'hFFFF_FFFF);
    check("b2b_mul_lo", lo, 32'hFFFF_FFD6);
    wait_busy(1'b0, nb, nd);
    check("b2b_div_busy_cycles", 64'(nb), 64'd33);
    check("b2b_div_hi", hi, 32'h2);
    check("b2b_div_lo", lo, 32'hE);

    // Asynchronous reset in the middle of a DIV
    drive(OP_DIV, 1'b0, 32'd1000, 32'd3, 1'b1);
    drive(OP_AND, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_mdu("mul_after_rst", OP_MULT, 1'b1, 32'hFFFF_FFFA, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
